paged_mem_writer: RTL and testbench
===================================

# paged_mem_writer

Write-side controller that sits directly upstream of the paged stub memory. It accepts a valid/ready stream of stub words tagged with an event page (bx), packs them into consecutive addresses of that page, and drives the memory's write port. Each write also updates that page's per-page entry count through its `nent_i*`/`nent_we*` ports. It clears a page's count when the page is opened and drops words beyond page capacity, raising a sticky overflow flag.

## Interface
Parameters:
- `RAM_WIDTH`, 18, data word width; matches the memory's `dina`.
- `NPAGES`, 8, number of pages (power of 2); `PAGE_BITS = clog2(NPAGES)`.
- `PAGE_DEPTH`, 128, entries per page (power of 2, ≤255); `ENT_BITS = clog2(PAGE_DEPTH)`.

Ports:
- `clka`  in  1  clock; all logic on rising edge.
- `rstb`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse that opens page `bx_in` for a new event.
- `bx_in`  in  PAGE_BITS  page to open; sampled only when `start`=1.
- `din_valid`  in  1  input word valid.
- `din`  in  RAM_WIDTH  input word.
- `din_ready`  out  1  word accepted on a cycle where `din_valid & din_ready`.
- `addra`  out  PAGE_BITS+ENT_BITS  write address `{page, count}`.
- `dina`  out  RAM_WIDTH  write data.
- `wea`  out  1  write enable.
- `nent_data`  out  8  new entry count for the page being updated.
- `nent_we`  out  NPAGES  one-hot count write enable; bit p drives `nent_we<p>`.
- `overflow`  out  1  sticky; a word was dropped in the current event.
- `ovf_count`  out  8  number of dropped words in the current event.

## Operation
State machine:
- IDLE: no page open; `din_ready`=0. `start` → CLEAR.
- CLEAR: lasts exactly one cycle; `din_ready`=0.
  - Latch `page`=bx captured with `start`; `count`=0; `overflow`=0; `ovf_count`=0.
  - Issue `nent_we[page]`=1 with `nent_data`=0.
  - Next state is ACTIVE.
  - A `start` arriving while in CLEAR re-captures `bx_in` and stays in CLEAR one more cycle.
- ACTIVE: `din_ready`=1.
  - Accepted word with `count` < PAGE_DEPTH: write `din` at `{page, count[ENT_BITS-1:0]}`, increment `count`, and issue `nent_we[page]` with `nent_data` = new `count`.
  - Accepted word with `count` = PAGE_DEPTH: word is dropped. No `wea`, no `nent_we`. `overflow` is set and `ovf_count` increments, saturating at 255.
  - `start` → CLEAR.
- Simultaneous `start` and accepted word in ACTIVE: the word is written to the old page first; CLEAR for the new page follows on the next cycle.
- Arithmetic: `count` is 8 bits, saturating at PAGE_DEPTH and never wrapping. The address uses only the low ENT_BITS bits, so it is valid only while `count` < PAGE_DEPTH.
- Reopening the same bx as the current page is legal: the count is cleared and memory contents are overwritten from address offset 0.

## Timing
- All outputs are registered. `wea`, `addra`, `dina`, `nent_we`, and `nent_data` appear 1 cycle after the accepting edge.
- Throughput: one word per cycle in ACTIVE.
- The CLEAR `nent_we` pulse appears 1 cycle after `start` is sampled.
- `wea` and `nent_we` are single-cycle pulses per event. They are never held.
- `din_ready` is a registered function of state and changes one cycle after the state transition.
- Reset values: state IDLE; `din_ready`=0, `wea`=0, `nent_we`=0, `addra`=0, `dina`=0, `nent_data`=0, `overflow`=0, `ovf_count`=0, `page`=0, `count`=0.
- Reset mid-event: in-flight writes are discarded. Counts already written to memory remain, and the memory is not cleared.

## Configuration
- `PAGED_WRITER_OVFCNT_EN` defined: the `ovf_count` 8-bit saturating drop counter is implemented as described.
- Not defined: the counter logic is removed and `ovf_count` is tied to 0. The `overflow` flag and drop behaviour are unchanged.

## Test plan
- Reset, then `start` with bx=3, then 5 consecutive words 0x00001..0x00005 → writes at addra 0x180..0x184; `nent_we`=0x08 with `nent_data` 0, then 1..5; `overflow`=0.
- Fill page 0 with 130 words (PAGE_DEPTH=128) → 128 writes at 0x000..0x07F; final `nent_data`=128; 2 words dropped; `overflow`=1; `ovf_count`=2 (0 without macro).
- In ACTIVE on page 1 with count=4, pulse `start` bx=2 on the same cycle as a valid word → word written at 0x084 with `nent_data`=5 to page 1; next cycle `nent_we`=0x04 with `nent_data`=0; `din_ready`=0 for one cycle; next word goes to 0x100.
- Toggle `din_valid` 1,0,1,0 in ACTIVE → writes only on the valid cycles, at consecutive addresses with no gaps.
- Assert `rstb` after 3 writes, then `start` bx=3 → all outputs return to reset values; CLEAR reissues `nent_data`=0 for page 3; first new write at 0x180.
- `din_valid`=1 in IDLE with no `start` → `din_ready`=0; no `wea`, no `nent_we`.

Source files
------------

// File: rtl/paged_mem_writer.sv
// Write-side controller for the paged stub memory: packs a valid/ready word stream into
// consecutive addresses of the open page and maintains per-page entry counts.
// Optional: define PAGED_WRITER_OVFCNT_EN to implement the saturating ovf_count drop counter.
module paged_mem_writer #(
  parameter int  RAM_WIDTH  = 18,
  parameter int  NPAGES     = 8,
  parameter int  PAGE_DEPTH = 128,
  localparam int PAGE_BITS  = $clog2(NPAGES),
  localparam int ENT_BITS   = $clog2(PAGE_DEPTH)
) (
  input  logic                          clka,
  input  logic                          rstb,
  input  logic                          start,
  input  logic [PAGE_BITS-1:0]          bx_in,
  input  logic                          din_valid,
  input  logic [RAM_WIDTH-1:0]          din,
  output logic                          din_ready,
  output logic [PAGE_BITS+ENT_BITS-1:0] addra,
  output logic [RAM_WIDTH-1:0]          dina,
  output logic                          wea,
  output logic [7:0]                    nent_data,
  output logic [NPAGES-1:0]             nent_we,
  output logic                          overflow,
  output logic [7:0]                    ovf_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ACTIVE
  } state_e;

  localparam logic [7:0] DEPTH_CNT = 8'(PAGE_DEPTH);

  function automatic logic [NPAGES-1:0] page_sel(input logic [PAGE_BITS-1:0] p);
    page_sel    = '0;
    page_sel[p] = 1'b1;
  endfunction

  state_e                          state_q, state_d;
  logic [PAGE_BITS-1:0]            bx_q, bx_d;
  logic [PAGE_BITS-1:0]            page_q, page_d;
  logic [7:0]                      count_q, count_d;
  logic                            din_ready_q, din_ready_d;
  logic [PAGE_BITS+ENT_BITS-1:0]   addra_q, addra_d;
  logic [RAM_WIDTH-1:0]            dina_q, dina_d;
  logic                            wea_q, wea_d;
  logic [7:0]                      nent_data_q, nent_data_d;
  logic [NPAGES-1:0]               nent_we_q, nent_we_d;
  logic                            overflow_q, overflow_d;
  logic                            accept;
`ifdef PAGED_WRITER_OVFCNT_EN
  logic [7:0]                      ovf_count_q, ovf_count_d;
`endif

  assign accept = din_valid & din_ready_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    bx_d        = bx_q;
    page_d      = page_q;
    count_d     = count_q;
    addra_d     = addra_q;
    dina_d      = dina_q;
    nent_data_d = nent_data_q;
    overflow_d  = overflow_q;
    wea_d       = 1'b0;
    nent_we_d   = '0;
`ifdef PAGED_WRITER_OVFCNT_EN
    ovf_count_d = ovf_count_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          bx_d    = bx_in;
        end
      end

      S_CLEAR: begin
        page_d      = bx_q;
        count_d     = '0;
        overflow_d  = 1'b0;
        nent_we_d   = page_sel(bx_q);
        nent_data_d = '0;
`ifdef PAGED_WRITER_OVFCNT_EN
        ovf_count_d = '0;
`endif
        // A repeated start re-opens with the newer page after one more clear cycle.
        if (start) bx_d = bx_in;
        else       state_d = S_ACTIVE;
      end

      S_ACTIVE: begin
        if (accept) begin
          if (count_q < DEPTH_CNT) begin
            wea_d       = 1'b1;
            addra_d     = {page_q, count_q[ENT_BITS-1:0]};
            dina_d      = din;
            count_d     = count_q + 8'd1;
            nent_we_d   = page_sel(page_q);
            nent_data_d = count_q + 8'd1;
          end else begin
            overflow_d = 1'b1;
`ifdef PAGED_WRITER_OVFCNT_EN
            if (ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
`endif
          end
        end
        // The word above still lands in the old page; the new page opens next cycle.
        if (start) begin
          state_d = S_CLEAR;
          bx_d    = bx_in;
        end
      end

      default: state_d = S_IDLE;
    endcase

    din_ready_d = (state_d == S_ACTIVE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q     <= S_IDLE;
      bx_q        <= '0;
      page_q      <= '0;
      count_q     <= '0;
      din_ready_q <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      wea_q       <= 1'b0;
      nent_data_q <= '0;
      nent_we_q   <= '0;
      overflow_q  <= 1'b0;
`ifdef PAGED_WRITER_OVFCNT_EN
      ovf_count_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      page_q      <= page_d;
      count_q     <= count_d;
      din_ready_q <= din_ready_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      wea_q       <= wea_d;
      nent_data_q <= nent_data_d;
      nent_we_q   <= nent_we_d;
      overflow_q  <= overflow_d;
`ifdef PAGED_WRITER_OVFCNT_EN
      ovf_count_q <= ovf_count_d;
`endif
    end
  end

  assign din_ready = din_ready_q;
  assign addra     = addra_q;
  assign dina      = dina_q;
  assign wea       = wea_q;
  assign nent_data = nent_data_q;
  assign nent_we   = nent_we_q;
  assign overflow  = overflow_q;
`ifdef PAGED_WRITER_OVFCNT_EN
  assign ovf_count = ovf_count_q;
`else
  assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_paged_mem_writer.sv
// Self-checking bench for paged_mem_writer: directed vector table, hand-written corner
// sequences and a random run, all compared against a transaction-level reference model.
module tb_paged_mem_writer;

  localparam int RAM_WIDTH  = 18;
  localparam int NPAGES     = 8;
  localparam int PAGE_DEPTH = 128;
  localparam int AW         = 10;

  logic                 clka = 1'b0;
  logic                 rstb = 1'b1;
  logic                 start = 1'b0;
  logic [2:0]           bx_in = '0;
  logic                 din_valid = 1'b0;
  logic [RAM_WIDTH-1:0] din = '0;
  logic                 din_ready;
  logic [AW-1:0]        addra;
  logic [RAM_WIDTH-1:0] dina;
  logic                 wea;
  logic [7:0]           nent_data;
  logic [NPAGES-1:0]    nent_we;
  logic                 overflow;
  logic [7:0]           ovf_count;

  paged_mem_writer #(
    .RAM_WIDTH (RAM_WIDTH),
    .NPAGES    (NPAGES),
    .PAGE_DEPTH(PAGE_DEPTH)
  ) dut (
    .clka     (clka),
    .rstb     (rstb),
    .start    (start),
    .bx_in    (bx_in),
    .din_valid(din_valid),
    .din      (din),
    .din_ready(din_ready),
    .addra    (addra),
    .dina     (dina),
    .wea      (wea),
    .nent_data(nent_data),
    .nent_we  (nent_we),
    .overflow (overflow),
    .ovf_count(ovf_count)
  );

  always #5 clka = ~clka;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  // Reference model: an event opens one edge after start is seen, and words are accepted
  // only when an event is open and no start was seen at the previous edge.
  bit             m_open, m_ready, m_clear_pend, m_wea, m_ovf;
  int             m_page, m_pend, m_cnt, m_drops;
  int             m_addra, m_dina, m_nent_data, m_we;

  task automatic model_reset();
    m_open = 0; m_ready = 0; m_clear_pend = 0; m_wea = 0; m_ovf = 0;
    m_page = 0; m_pend = 0; m_cnt = 0; m_drops = 0;
    m_addra = 0; m_dina = 0; m_nent_data = 0; m_we = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc   = din_valid && m_ready;
    m_wea = 0;
    m_we  = 0;
    if (m_clear_pend) begin
      m_page = m_pend; m_cnt = 0; m_ovf = 0; m_drops = 0;
      m_we = 1 << m_page; m_nent_data = 0;
    end else if (acc) begin
      if (m_cnt < PAGE_DEPTH) begin
        m_addra = m_page * PAGE_DEPTH + m_cnt;
        m_dina  = int'(din);
        m_cnt++;
        m_wea = 1; m_we = 1 << m_page; m_nent_data = m_cnt;
      end else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    m_clear_pend = start;
    if (start) begin
      m_pend = int'(bx_in);
      m_open = 1;
    end
    m_ready = m_open && !start;
  endtask

  task automatic compare_model();
    int exp_ovfc;
`ifdef PAGED_WRITER_OVFCNT_EN
    exp_ovfc = m_drops;
`else
    exp_ovfc = 0;
`endif
    check("din_ready", 32'(din_ready), 32'(m_ready));
    check("wea",       32'(wea),       32'(m_wea));
    check("nent_we",   32'(nent_we),   32'(m_we));
    check("addra",     32'(addra),     32'(m_addra));
    check("dina",      32'(dina),      32'(m_dina));
    check("nent_data", 32'(nent_data), 32'(m_nent_data));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("ovf_count", 32'(ovf_count), 32'(exp_ovfc));
  endtask

  task automatic step(input logic s, input logic [2:0] b, input logic v, input logic [RAM_WIDTH-1:0] d);
    start = s; bx_in = b; din_valid = v; din = d;
    @(posedge clka);
    cycle++;
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rstb = 1'b1; start = 1'b0; din_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clka);
      cycle++;
      model_reset();
      #1;
      compare_model();
    end
    rstb = 1'b0;
  endtask

  typedef struct {
    logic                 s;
    logic [2:0]           bx;
    logic                 v;
    logic [RAM_WIDTH-1:0] d;
    logic                 e_rdy;
    logic                 e_wea;
    logic [AW-1:0]        e_addr;
    logic [NPAGES-1:0]    e_we;
    logic [7:0]           e_nd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // valid in IDLE, open page 3, clear pulse, five words, then quiet
    vecs.push_back('{1'b0, 3'd0, 1'b1, 18'h7, 1'b0, 1'b0, 10'h000, 8'h00, 8'd0});
    vecs.push_back('{1'b1, 3'd3, 1'b0, 18'h0, 1'b0, 1'b0, 10'h000, 8'h00, 8'd0});
    vecs.push_back('{1'b0, 3'd0, 1'b0, 18'h0, 1'b1, 1'b0, 10'h000, 8'h08, 8'd0});
    for (int i = 1; i <= 5; i++)
      vecs.push_back('{1'b0, 3'd0, 1'b1, 18'(i), 1'b1, 1'b1, 10'(10'h180 + i - 1), 8'h08, 8'(i)});
    vecs.push_back('{1'b0, 3'd0, 1'b0, 18'h0, 1'b1, 1'b0, 10'h184, 8'h00, 8'd5});

    model_reset();
    do_reset();
    check("reset_ready", 32'(din_ready), 32'd0);
    check("reset_addra", 32'(addra), 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].s, vecs[i].bx, vecs[i].v, vecs[i].d);
      check($sformatf("vec%0d_ready", i), 32'(din_ready), 32'(vecs[i].e_rdy));
      check($sformatf("vec%0d_wea", i),   32'(wea),       32'(vecs[i].e_wea));
      check($sformatf("vec%0d_addra", i), 32'(addra),     32'(vecs[i].e_addr));
      check($sformatf("vec%0d_we", i),    32'(nent_we),   32'(vecs[i].e_we));
      check($sformatf("vec%0d_nd", i),    32'(nent_data), 32'(vecs[i].e_nd));
    end
    check("t1_overflow", 32'(overflow), 32'd0);

    // fill page 0 past capacity
    do_reset();
    step(1'b1, 3'd0, 1'b0, '0);
    step(1'b0, 3'd0, 1'b0, '0);
    for (int i = 0; i < 130; i++) begin
      step(1'b0, 3'd0, 1'b1, 18'($urandom));
      if (i == 0)   check("fill_first_addra", 32'(addra), 32'h000);
      if (i == 127) begin
        check("fill_last_addra", 32'(addra), 32'h07F);
        check("fill_last_nd",    32'(nent_data), 32'd128);
        check("fill_no_ovf",     32'(overflow), 32'd0);
      end
      if (i >= 128) check("fill_drop_wea", 32'(wea), 32'd0);
    end
    check("fill_overflow", 32'(overflow), 32'd1);
`ifdef PAGED_WRITER_OVFCNT_EN
    check("fill_ovf_count", 32'(ovf_count), 32'd2);
`else
    check("fill_ovf_count", 32'(ovf_count), 32'd0);
`endif

    // start colliding with an accepted word on page 1 at count 4
    do_reset();
    step(1'b1, 3'd1, 1'b0, '0);
    step(1'b0, 3'd0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 1'b1, 18'(16 + i));
    step(1'b1, 3'd2, 1'b1, 18'h2AAAA);
    check("col_addra", 32'(addra), 32'h084);
    check("col_nd",    32'(nent_data), 32'd5);
    check("col_we",    32'(nent_we), 32'h02);
    check("col_ready", 32'(din_ready), 32'd0);
    step(1'b0, 3'd0, 1'b1, 18'h11111);
    check("col_clr_we", 32'(nent_we), 32'h04);
    check("col_clr_nd", 32'(nent_data), 32'd0);
    check("col_clr_wea", 32'(wea), 32'd0);
    step(1'b0, 3'd0, 1'b1, 18'h22222);
    check("col_next_addra", 32'(addra), 32'h100);

    // toggled valid: writes land back to back with no gaps
    step(1'b0, 3'd0, 1'b1, 18'h3);
    check("tog_addr1", 32'(addra), 32'h101);
    step(1'b0, 3'd0, 1'b0, 18'h4);
    check("tog_wea0", 32'(wea), 32'd0);
    step(1'b0, 3'd0, 1'b1, 18'h5);
    check("tog_addr2", 32'(addra), 32'h102);
    step(1'b0, 3'd0, 1'b0, 18'h6);

    // back-to-back starts (model-checked)
    step(1'b1, 3'd5, 1'b1, '0);
    step(1'b1, 3'd6, 1'b1, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b1, 18'(i));

    // reset mid-event, then reopen page 3
    do_reset();
    step(1'b1, 3'd4, 1'b0, '0);
    step(1'b0, 3'd0, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b1, 18'(i + 1));
    do_reset();
    check("rst_wea",   32'(wea), 32'd0);
    check("rst_addra", 32'(addra), 32'd0);
    check("rst_nd",    32'(nent_data), 32'd0);
    step(1'b1, 3'd3, 1'b0, '0);
    step(1'b0, 3'd0, 1'b1, '0);
    check("rst_clr_we", 32'(nent_we), 32'h08);
    check("rst_clr_nd", 32'(nent_data), 32'd0);
    step(1'b0, 3'd0, 1'b1, 18'h9);
    check("rst_first_addra", 32'(addra), 32'h180);

    // random run against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      step(1'($urandom_range(0, 199) == 0), 3'($urandom), 1'($urandom_range(0, 9) < 7), 18'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
